uart_rx_fifo: RTL

- Receive-side buffer directly downstream of the UART top module.
- Captures each received byte on the rising edge of the receiver's done flag and checks the received parity bit against the configured parity mode.
- Stores byte plus parity-error tag in a circular FIFO for the consumer (command decoder / host logic).
- Reports overrun, full/empty, fill level and a saturating parity-error count.

---
 rtl/uart_rx_fifo_if.sv | 31 +++
 rtl/uart_rx_fifo.sv | 97 +++++++++
 2 files changed

// File: rtl/uart_rx_fifo_if.sv
// Bundles the UART receive-side inputs and the consumer read/status signals of uart_rx_fifo.
// The FIFO uses the slave view; whatever drives the receiver and consumer side uses master.
interface uart_rx_fifo_if #(
  parameter int DATA_W = 8,
  parameter int ADDR_W = 4
);
  logic [1:0]        parity_type;
  logic [DATA_W-1:0] rx_data;
  logic              rx_flag;
  logic              rx_parity;
  logic              rd_en;
  logic              err_clr;
  logic [DATA_W-1:0] rd_data;
  logic              rd_err;
  logic              rd_valid;
  logic              empty;
  logic              full;
  logic [ADDR_W:0]   count;
  logic              overrun;
  logic [7:0]        parity_err_cnt;

  modport slave (
    input  parity_type, rx_data, rx_flag, rx_parity, rd_en, err_clr,
    output rd_data, rd_err, rd_valid, empty, full, count, overrun, parity_err_cnt
  );

  modport master (
    output parity_type, rx_data, rx_flag, rx_parity, rd_en, err_clr,
    input  rd_data, rd_err, rd_valid, empty, full, count, overrun, parity_err_cnt
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Receive-side FIFO behind the UART: edge-detects the done flag, checks parity,
// stores {perr, byte} and reports fill level, overrun and a saturating parity-error count.
module uart_rx_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input logic          clk,
  input logic          reset,
  uart_rx_fifo_if.slave bus
);
  localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W+1)'(DEPTH);

  logic [DATA_W:0]   mem [DEPTH];
  logic [ADDR_W-1:0] wr_ptr, rd_ptr;
  logic [ADDR_W:0]   count_r, count_nxt;
  logic              empty_r, full_r, rx_flag_q;
  logic              rd_valid_r, rd_err_r, overrun_r;
  logic [DATA_W-1:0] rd_data_r;
  logic [7:0]        perr_cnt_r;
  logic              wr, rd, push, perr;

  function automatic logic parity_fail(input logic [1:0] mode,
                                       input logic [DATA_W-1:0] data,
                                       input logic par);
    case (mode)
      2'b10:   return par != (^data);
      2'b01:   return par != (~^data);
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

  // A read on a full FIFO frees the slot the coincident write lands in.
  assign wr   = bus.rx_flag & ~rx_flag_q;
  assign rd   = bus.rd_en & ~empty_r;
  assign push = wr & (~full_r | rd);
  assign perr = parity_fail(bus.parity_type, bus.rx_data, bus.rx_parity);

  always_comb begin
    count_nxt = count_r;
    case ({push, rd})
      2'b10:   count_nxt = count_r + 1'b1;
      2'b01:   count_nxt = count_r - 1'b1;
      default: count_nxt = count_r;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= {perr, bus.rx_data};
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_r    <= '0;
      empty_r    <= 1'b1;
      full_r     <= 1'b0;
      rx_flag_q  <= 1'b1;
      rd_data_r  <= '0;
      rd_err_r   <= 1'b0;
      rd_valid_r <= 1'b0;
      overrun_r  <= 1'b0;
      perr_cnt_r <= '0;
    end else begin
      rx_flag_q  <= bus.rx_flag;
      rd_valid_r <= rd;
      count_r    <= count_nxt;
      empty_r    <= (count_nxt == '0);
      full_r     <= (count_nxt == FULL_CNT);
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (rd) begin
        rd_ptr    <= rd_ptr + 1'b1;
        rd_data_r <= mem[rd_ptr][DATA_W-1:0];
        rd_err_r  <= mem[rd_ptr][DATA_W];
      end
      // Set/increment events take priority over a coincident clear.
      if (wr && !push)   overrun_r <= 1'b1;
      else if (bus.err_clr) overrun_r <= 1'b0;
      if (push && perr)  perr_cnt_r <= bus.err_clr ? 8'd1 : sat_inc(perr_cnt_r);
      else if (bus.err_clr) perr_cnt_r <= '0;
    end
  end

  assign bus.rd_data        = rd_data_r;
  assign bus.rd_err         = rd_err_r;
  assign bus.rd_valid       = rd_valid_r;
  assign bus.empty          = empty_r;
  assign bus.full           = full_r;
  assign bus.count          = count_r;
  assign bus.overrun        = overrun_r;
  assign bus.parity_err_cnt = perr_cnt_r;
endmodule
